// File: rtl/max_finder_seq.sv
// Sequential arg-max: captures a vector of signed neuron outputs and scans one element per cycle,
// then pulses the index and value of the largest element.
`timescale 1ns/1ps
module max_finder_seq #(
   parameter int NUM_INPUT  = 10,
   parameter int DATA_WIDTH = 16,
   parameter int IDX_WIDTH  = 32
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic [NUM_INPUT*DATA_WIDTH-1:0] i_data,
   input  logic                            i_valid,
   input  logic                            i_clr_overrun,
   output logic [IDX_WIDTH-1:0]            o_data,
   output logic [DATA_WIDTH-1:0]           o_max,
   output logic                            o_data_valid,
   output logic                            o_busy,
   output logic                            o_overrun
);

   localparam int CNT_W = (NUM_INPUT > 1) ? $clog2(NUM_INPUT) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_INPUT - 1);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SCAN,
      S_DONE
   } state_t;

   state_t                          state_q, state_d;
   logic [NUM_INPUT*DATA_WIDTH-1:0] buf_q;
   logic [DATA_WIDTH-1:0]           max_q, max_d;
   logic [DATA_WIDTH-1:0]           res_max_q, res_max_d;
   logic [CNT_W-1:0]                idx_q, idx_d;
   logic [CNT_W-1:0]                res_idx_q, res_idx_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic                            overrun_q, overrun_d;
   logic [DATA_WIDTH-1:0]           cur_elem;
   logic                            accept;

   assign accept   = (state_q == S_IDLE) && i_valid;
   assign cur_elem = buf_q[int'(cnt_q)*DATA_WIDTH +: DATA_WIDTH];

   // NOTE: every variable gets its hold value first so no path leaves it unassigned (no latch).
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      max_d     = max_q;
      idx_d     = idx_q;
      res_max_d = res_max_q;
      res_idx_d = res_idx_q;
      overrun_d = overrun_q;

      unique case (state_q)
         S_IDLE: begin
            if (i_valid) begin
               max_d = i_data[DATA_WIDTH-1:0];
               idx_d = '0;
               if (NUM_INPUT == 1) begin
                  state_d   = S_DONE;
                  cnt_d     = '0;
                  res_max_d = i_data[DATA_WIDTH-1:0];
                  res_idx_d = '0;
               end else begin
                  state_d = S_SCAN;
                  cnt_d   = CNT_W'(1);
               end
            end
         end
         S_SCAN: begin
            // Strict greater-than keeps the lowest index on ties.
            if ($signed(cur_elem) > $signed(max_q)) begin
               max_d = cur_elem;
               idx_d = cnt_q;
            end
            if (cnt_q == LAST_IDX) begin
               state_d   = S_DONE;
               cnt_d     = '0;
               res_max_d = max_d;
               res_idx_d = idx_d;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A new overrun event takes priority over a simultaneous clear.
      if (i_clr_overrun) overrun_d = 1'b0;
      if (i_valid && (state_q != S_IDLE)) overrun_d = 1'b1;
   end

   // NOTE: state registers use non-blocking assignments so all flops update together on the edge.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         cnt_q     <= '0;
         max_q     <= '0;
         idx_q     <= '0;
         res_max_q <= '0;
         res_idx_q <= '0;
         overrun_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         max_q     <= max_d;
         idx_q     <= idx_d;
         res_max_q <= res_max_d;
         res_idx_q <= res_idx_d;
         overrun_q <= overrun_d;
      end
   end

   // NOTE: the data buffer is deliberately not reset; it is always written before it is read.
   always_ff @(posedge clk) begin
      if (accept) buf_q <= i_data;
   end

   assign o_data       = IDX_WIDTH'(res_idx_q);
   assign o_max        = res_max_q;
   assign o_data_valid = (state_q == S_DONE);
   assign o_busy       = (state_q != S_IDLE);
   assign o_overrun    = overrun_q;

endmodule

// File: doc/max_finder_seq.md
# max_finder_seq

Sequential arg-max stage at the output of the final zyNet layer. It captures the layer's parallel output vector on a valid pulse and scans one element per cycle to find the largest signed value. It then presents the winning neuron index (the "detected number") with a one-cycle valid pulse. That pulse drives the interrupt and the AXI-lite result register at offset 8.

## Interface
- NUM_INPUT, 10, number of neuron outputs compared (≥1)
- DATA_WIDTH, 16, width of each neuron output, two's-complement signed
- IDX_WIDTH, 32, width of the index output (zero-extended)
- clk  in  1  single clock; all logic rising-edge
- rst  in  1  synchronous, active-high reset
- i_data  in  NUM_INPUT*DATA_WIDTH  neuron outputs; element k at bits [k*DATA_WIDTH +: DATA_WIDTH]
- i_valid  in  1  one-cycle qualifier for i_data
- i_clr_overrun  in  1  clears o_overrun
- o_data  out  IDX_WIDTH  index of maximum element
- o_max  out  DATA_WIDTH  value of maximum element
- o_data_valid  out  1  one-cycle result pulse
- o_busy  out  1  scan in progress
- o_overrun  out  1  sticky: an i_valid arrived while busy

## Operation
- States:
  - IDLE:
    - On i_valid, latch the whole i_data vector into an internal buffer.
    - Load max ← element 0, idx ← 0, cnt ← 1.
    - Go to SCAN, or to DONE if NUM_INPUT==1.
  - SCAN, each cycle:
    - Signed-compare element cnt against max. If strictly greater, max ← element, idx ← cnt.
    - cnt ← cnt+1.
    - After processing cnt==NUM_INPUT-1, go to DONE.
  - DONE, single cycle:
    - Drive o_data_valid=1 with o_data/o_max holding the final result.
    - Go to IDLE.
- Ties: the lowest index wins (strict > only).
- Comparison is signed. 16'h8000 is the most negative value and 16'h7FFF the most positive.
- o_data is idx zero-extended to IDX_WIDTH. o_data and o_max hold their last result until the next DONE, not only during the pulse.
- o_busy=1 in SCAN and DONE, 0 in IDLE.
- i_valid while o_busy=1:
  - The input is ignored; the in-flight scan is unaffected.
  - o_overrun is set.
- i_clr_overrun:
  - Clears o_overrun.
  - If asserted in the same cycle as a new overrun event, the set wins.
- Input buffer: i_data is sampled only at acceptance. Later changes on i_data do not affect the scan.

## Timing
- Reset values: o_data=0, o_max=0, o_data_valid=0, o_busy=0, o_overrun=0, state IDLE, cnt=0.
- Capture edge E (i_valid=1 in IDLE) → o_busy=1 from E.
- o_data_valid=1 in the cycle following edge E+NUM_INPUT−1, i.e. latency NUM_INPUT cycles from capture.
  - NUM_INPUT=10: 10 cycles.
  - NUM_INPUT=1: 1 cycle.
- o_busy falls on the edge ending DONE. i_valid during DONE counts as an overrun; i_valid in the next cycle is accepted.
- Minimum spacing between accepted vectors: NUM_INPUT+1 cycles.
- rst mid-scan: the next cycle is IDLE with all outputs at reset values. No o_data_valid pulse for the aborted vector.
- rst and i_valid in the same cycle: rst wins and the vector is dropped.
- No combinational path from inputs to outputs.

## Test plan
- Reset: hold rst 3 cycles while toggling i_valid → all outputs 0, no o_data_valid.
- Basic, NUM_INPUT=10: elements {5,3,9,−2,0,1,9,4,7,8} (16-bit), i_valid at edge E → o_data_valid only in the cycle after E+9 edges, o_data=2 (tie with index 6 resolved low), o_max=9, o_busy high cycles E..E+10.
- Signed and edges:
  - All elements 16'h8000 except element 9 = 16'h8001 → o_data=9, o_max=16'h8001.
  - All equal 16'h7FFF → o_data=0.
- Back-to-back:
  - Second i_valid 4 cycles after first → ignored; first result unchanged; o_overrun=1.
  - Clear via i_clr_overrun → 0.
  - Third i_valid the cycle after DONE → accepted, result 10 cycles later.
- Reset mid-operation: assert rst at scan step 5 → o_busy=0 next cycle, no o_data_valid within 20 cycles; a subsequent vector with max at index 7 → o_data=7.
- Parameter sweep NUM_INPUT=1, DATA_WIDTH=8: element 8'hF0 → o_data_valid 1 cycle after capture, o_data=0, o_max=8'hF0.
